// File: rtl/arb_pkg.sv
// Shared types for the icache/dcache cacheline arbiter.
//   arb_state_t : arbiter FSM states
//   requester_t : identifies which cache holds (or last held) the memory port
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D,
    RELEASE
  } arb_state_t;

  typedef enum logic {
    REQ_I,
    REQ_D
  } requester_t;

endpackage

// File: rtl/rr_grant2.sv
// Combinational two-way round-robin pick between the icache and the dcache.
//   i_req_i        : icache is requesting
//   d_req_i        : dcache is requesting
//   last_grant_i   : requester granted most recently
//   gnt_valid_o    : at least one requester is asking
//   gnt_o          : chosen requester (meaningful only when gnt_valid_o)
module rr_grant2
  import arb_pkg::*;
(
  input  logic       i_req_i,
  input  logic       d_req_i,
  input  requester_t last_grant_i,
  output logic       gnt_valid_o,
  output requester_t gnt_o
);

  always_comb begin
    gnt_valid_o = i_req_i | d_req_i;
    gnt_o       = REQ_I;
    if (i_req_i && d_req_i) begin
      // On a tie the requester not served last time wins.
      gnt_o = (last_grant_i == REQ_I) ? REQ_D : REQ_I;
    end else if (d_req_i) begin
      gnt_o = REQ_D;
    end
  end

endmodule

// File: rtl/cacheline_arbiter.sv
// Round-robin arbiter sharing one cacheline memory port between icache and dcache.
// One transaction is granted at a time; its address, command and writeback data are
// latched, and the downstream response is routed to the granted cache only.
//   clk, rst                 : clock, asynchronous active-low reset
//   i_pmem_*                 : icache line read port
//   d_pmem_*                 : dcache line read / writeback port
//   mem_address/read/write/wdata : latched downstream command
//   mem_rdata, mem_resp      : downstream read data and completion pulse
module cacheline_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,

  input  logic [ADDR_W-1:0] i_pmem_address,
  input  logic              i_pmem_read,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,

  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,

  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  arb_state_t        state_q, state_d;
  requester_t        last_grant_q, last_grant_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              read_q, read_d;
  logic              write_q, write_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;

  logic       gnt_valid;
  requester_t gnt;

  rr_grant2 u_rr_grant2 (
    .i_req_i      (i_pmem_read),
    .d_req_i      (d_pmem_read | d_pmem_write),
    .last_grant_i (last_grant_q),
    .gnt_valid_o  (gnt_valid),
    .gnt_o        (gnt)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    read_d       = read_q;
    write_d      = write_q;
    wdata_d      = wdata_q;

    unique case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          last_grant_d = gnt;
          if (gnt == REQ_I) begin
            addr_d  = i_pmem_address;
            read_d  = 1'b1;
            write_d = 1'b0;
            state_d = SERVE_I;
          end else begin
            // Read and write together is illegal; the write takes precedence.
            addr_d  = d_pmem_address;
            write_d = d_pmem_write;
            read_d  = ~d_pmem_write;
            wdata_d = d_pmem_wdata;
            state_d = SERVE_D;
          end
        end
      end
      SERVE_I, SERVE_D: begin
        if (mem_resp) begin
          read_d  = 1'b0;
          write_d = 1'b0;
          state_d = RELEASE;
        end
      end
      // One dead cycle lets the served cache drop its request before resampling.
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= REQ_D;
      addr_q       <= '0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      read_q       <= read_d;
      write_q      <= write_d;
      wdata_q      <= wdata_d;
    end
  end

  assign mem_address  = addr_q;
  assign mem_read     = read_q;
  assign mem_write    = write_q;
  assign mem_wdata    = wdata_q;

  assign i_pmem_resp  = mem_resp & (state_q == SERVE_I);
  assign d_pmem_resp  = mem_resp & (state_q == SERVE_D);
  assign i_pmem_rdata = mem_rdata;
  assign d_pmem_rdata = mem_rdata;

endmodule

// File: tb/tb_cacheline_arbiter.sv
// Directed bench for cacheline_arbiter. Expected downstream transactions are pushed to a
// queue as requests are raised and popped as commands appear on the memory side.
module tb_cacheline_arbiter;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned LINE_W = 256;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [ADDR_W-1:0] i_pmem_address = '0;
  logic              i_pmem_read = 1'b0;
  logic [LINE_W-1:0] i_pmem_rdata;
  logic              i_pmem_resp;
  logic [ADDR_W-1:0] d_pmem_address = '0;
  logic              d_pmem_read = 1'b0;
  logic              d_pmem_write = 1'b0;
  logic [LINE_W-1:0] d_pmem_wdata = '0;
  logic [LINE_W-1:0] d_pmem_rdata;
  logic              d_pmem_resp;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_read;
  logic              mem_write;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata = '0;
  logic              mem_resp = 1'b0;

  cacheline_arbiter #(
    .ADDR_W (ADDR_W),
    .LINE_W (LINE_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_pmem_address (i_pmem_address),
    .i_pmem_read    (i_pmem_read),
    .i_pmem_rdata   (i_pmem_rdata),
    .i_pmem_resp    (i_pmem_resp),
    .d_pmem_address (d_pmem_address),
    .d_pmem_read    (d_pmem_read),
    .d_pmem_write   (d_pmem_write),
    .d_pmem_wdata   (d_pmem_wdata),
    .d_pmem_rdata   (d_pmem_rdata),
    .d_pmem_resp    (d_pmem_resp),
    .mem_address    (mem_address),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .mem_resp       (mem_resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit                is_d;
    bit                wr;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wdata;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   n_total = 0;
  int   n_pass  = 0;

  localparam logic [LINE_W-1:0] PAT_A = {8{32'hA5A5_0001}};
  localparam logic [LINE_W-1:0] PAT_B = {8{32'hB00B_1234}};
  localparam logic [LINE_W-1:0] PAT_C = {8{32'hC0DE_7777}};
  localparam logic [LINE_W-1:0] PAT_E = {8{32'h0E0E_5A5A}};

  task automatic chk(input string tag, input logic [LINE_W-1:0] obs,
                     input logic [LINE_W-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // The dcache never drives read and write together in this bench.
  always @(negedge clk) begin
    if (rst && d_pmem_read && d_pmem_write) begin
      n_total++;
      assert (0) else $error("FAIL illegal_rw observed=1 expected=0");
    end
  end

  function automatic exp_t mk(input bit is_d, input bit wr, input logic [ADDR_W-1:0] a,
                              input logic [LINE_W-1:0] wd);
    exp_t e;
    e.is_d  = is_d;
    e.wr    = wr;
    e.addr  = a;
    e.wdata = wd;
    return e;
  endfunction

  // Wait (bounded) for a downstream command, then check it against the scoreboard head.
  task automatic wait_cmd(input string tag);
    int k;
    k = 0;
    while (!(mem_read || mem_write) && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() == 0) begin
      chk({tag, "_unexpected"}, 1, 0);
      return;
    end
    cur = exp_q.pop_front();
    if (k >= 20) begin
      chk({tag, "_timeout"}, 1, 0);
      return;
    end
    chk({tag, "_addr"}, mem_address, cur.addr);
    chk({tag, "_read"}, mem_read, !cur.wr);
    chk({tag, "_write"}, mem_write, cur.wr);
    if (cur.wr) chk({tag, "_wdata"}, mem_wdata, cur.wdata);
  endtask

  // Hold the command for lat cycles, then pulse mem_resp; returns in the RELEASE cycle.
  task automatic serve(input string tag, input int lat, input logic [LINE_W-1:0] rd);
    repeat (lat - 1) @(negedge clk);
    chk({tag, "_held"}, {mem_read, mem_write}, {!cur.wr, cur.wr});
    mem_resp  = 1'b1;
    mem_rdata = rd;
    #1;
    chk({tag, "_iresp"}, i_pmem_resp, !cur.is_d);
    chk({tag, "_dresp"}, d_pmem_resp, cur.is_d);
    if (cur.is_d) chk({tag, "_drdata"}, d_pmem_rdata, rd);
    else          chk({tag, "_irdata"}, i_pmem_rdata, rd);
    @(negedge clk);
    mem_resp = 1'b0;
    chk({tag, "_cmd_clr"}, {mem_read, mem_write, i_pmem_resp, d_pmem_resp}, 0);
  endtask

  initial begin
    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_outs", {mem_read, mem_write, i_pmem_resp, d_pmem_resp}, 0);
    chk("rst_addr", mem_address, 0);
    chk("rst_wdata", mem_wdata, 0);
    rst = 1'b1;
    @(negedge clk);

    // Lone icache read.
    i_pmem_address = 32'h0000_1000;
    i_pmem_read    = 1'b1;
    exp_q.push_back(mk(0, 0, 32'h0000_1000, '0));
    #1 chk("iread_not_yet", mem_read, 0);
    @(negedge clk);
    chk("iread_latency", mem_read, 1);
    wait_cmd("iread");
    serve("iread", 4, PAT_A);
    i_pmem_read = 1'b0;

    // Stray mem_resp in RELEASE and then in IDLE.
    mem_resp = 1'b1;
    #1 chk("stray_rel", {i_pmem_resp, d_pmem_resp}, 0);
    @(negedge clk);
    chk("stray_idle", {i_pmem_resp, d_pmem_resp, mem_read, mem_write}, 0);
    @(negedge clk);
    mem_resp = 1'b0;
    chk("stray_idle2", {mem_read, mem_write}, 0);

    // Lone dcache writeback (also proves the FSM is still in IDLE after the stray pulses).
    d_pmem_address = 32'h0000_2040;
    d_pmem_wdata   = PAT_B;
    d_pmem_write   = 1'b1;
    exp_q.push_back(mk(1, 1, 32'h0000_2040, PAT_B));
    @(negedge clk);
    chk("dwr_latency", mem_write, 1);
    wait_cmd("dwr");
    serve("dwr", 2, PAT_C);
    d_pmem_write = 1'b0;
    @(negedge clk);

    // Tie: last grant is D, so I goes first; held requests alternate.
    i_pmem_address = 32'h0000_3000;
    d_pmem_address = 32'h0000_4000;
    i_pmem_read    = 1'b1;
    d_pmem_read    = 1'b1;
    exp_q.push_back(mk(0, 0, 32'h0000_3000, '0));
    exp_q.push_back(mk(1, 0, 32'h0000_4000, '0));
    exp_q.push_back(mk(0, 0, 32'h0000_3000, '0));
    exp_q.push_back(mk(1, 0, 32'h0000_4000, '0));
    wait_cmd("tie0"); serve("tie0", 1, PAT_A);
    wait_cmd("tie1"); serve("tie1", 2, PAT_B);
    wait_cmd("tie2"); serve("tie2", 1, PAT_C);
    wait_cmd("tie3"); serve("tie3", 3, PAT_E);
    i_pmem_read = 1'b0;
    d_pmem_read = 1'b0;
    @(negedge clk);

    // Writeback then fill with the icache pending.
    d_pmem_address = 32'h0000_5000;
    d_pmem_wdata   = PAT_E;
    d_pmem_write   = 1'b1;
    exp_q.push_back(mk(1, 1, 32'h0000_5000, PAT_E));
    @(negedge clk);
    i_pmem_address = 32'h0000_6000;
    i_pmem_read    = 1'b1;
    wait_cmd("wbf_wr");
    d_pmem_wdata = PAT_A;  // must not disturb the latched writeback
    serve("wbf_wr", 2, PAT_B);
    d_pmem_write   = 1'b0;
    d_pmem_read    = 1'b1;
    d_pmem_address = 32'h0000_5000;
    exp_q.push_back(mk(0, 0, 32'h0000_6000, '0));
    exp_q.push_back(mk(1, 0, 32'h0000_5000, '0));
    wait_cmd("wbf_i");  serve("wbf_i", 2, PAT_C);
    i_pmem_read = 1'b0;
    wait_cmd("wbf_rd"); serve("wbf_rd", 2, PAT_A);
    d_pmem_read = 1'b0;
    @(negedge clk);

    // Reset during SERVE_D.
    d_pmem_address = 32'h0000_7000;
    d_pmem_wdata   = PAT_C;
    d_pmem_write   = 1'b1;
    exp_q.push_back(mk(1, 1, 32'h0000_7000, PAT_C));
    wait_cmd("mrst_pre");
    rst      = 1'b0;
    mem_resp = 1'b1;
    #1;
    chk("mrst_cmd", {mem_read, mem_write, i_pmem_resp, d_pmem_resp}, 0);
    chk("mrst_addr", mem_address, 0);
    chk("mrst_wdata", mem_wdata, 0);
    @(negedge clk);
    mem_resp       = 1'b0;
    d_pmem_write   = 1'b0;
    d_pmem_read    = 1'b1;
    i_pmem_address = 32'h0000_8000;
    i_pmem_read    = 1'b1;
    exp_q.push_back(mk(0, 0, 32'h0000_8000, '0));
    exp_q.push_back(mk(1, 0, 32'h0000_7000, '0));
    @(negedge clk);
    rst = 1'b1;
    wait_cmd("mrst_i"); serve("mrst_i", 1, PAT_E);
    i_pmem_read = 1'b0;
    wait_cmd("mrst_d"); serve("mrst_d", 1, PAT_B);
    d_pmem_read = 1'b0;
    @(negedge clk);
    chk("end_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cacheline_arbiter.md
# cacheline_arbiter

Two-port round-robin arbiter that shares the single 256-bit cacheline memory port between the instruction cache and the data cache. It sits between the two caches' `pmem_*` ports and the line-level memory side (cacheline adaptor / L2). Each cache issues whole-line reads, and the dcache also issues whole-line writebacks. The arbiter grants one transaction at a time, latches its address and data, and routes the response back to the granted cache only.

## Interface
Parameters:
- `ADDR_W`, 32, byte address width.
- `LINE_W`, 256, cacheline width in bits.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset (asserted when 0).
- `i_pmem_address`  in  ADDR_W  icache line address.
- `i_pmem_read`  in  1  icache line read request; held until `i_pmem_resp`.
- `i_pmem_rdata`  out  LINE_W  line data to the icache.
- `i_pmem_resp`  out  1  icache transaction complete.
- `d_pmem_address`  in  ADDR_W  dcache line address.
- `d_pmem_read`  in  1  dcache fill request; held until `d_pmem_resp`.
- `d_pmem_write`  in  1  dcache writeback request; held until `d_pmem_resp`.
- `d_pmem_wdata`  in  LINE_W  writeback line.
- `d_pmem_rdata`  out  LINE_W  line data to the dcache.
- `d_pmem_resp`  out  1  dcache transaction complete.
- `mem_address`  out  ADDR_W  latched address of the granted transaction.
- `mem_read`, `mem_write`  out  1  downstream command; one-hot or both low.
- `mem_wdata`  out  LINE_W  latched writeback data.
- `mem_rdata`  in  LINE_W  downstream read data.
- `mem_resp`  in  1  downstream completion, 1-cycle pulse.

## Operation
- FSM states: `IDLE`, `SERVE_I`, `SERVE_D`, `RELEASE`.
- `IDLE`:
  - Sample requests. `i_req = i_pmem_read`; `d_req = d_pmem_read | d_pmem_write`.
  - Only one requesting: grant it.
  - Both requesting: grant the one not recorded in `last_grant`.
  - On a grant:
    - Latch address and command into `mem_address`, `mem_read`, `mem_write`.
    - For a dcache grant, also latch `d_pmem_wdata` into `mem_wdata`.
    - Update `last_grant`.
    - Go to `SERVE_I` or `SERVE_D`.
- `SERVE_x`:
  - Hold the latched command until `mem_resp`.
  - Then clear `mem_read` and `mem_write` and go to `RELEASE`.
- `RELEASE`:
  - One cycle with no command and no request sampling, so the served cache can drop its request.
  - Then go to `IDLE`.
- `d_pmem_read` and `d_pmem_write` both high is illegal. The arbiter treats it as a write; the bench flags it with an assertion.
- Response routing is combinational:
  - `i_pmem_resp = mem_resp & (state == SERVE_I)`; `d_pmem_resp = mem_resp & (state == SERVE_D)`.
  - `i_pmem_rdata = d_pmem_rdata = mem_rdata` unconditionally.
- `mem_resp` outside `SERVE_*` is ignored: no resp pulse, no state change.
- Request changes during `SERVE_*` do not affect the latched transaction.

## Timing
- Reset values:
  - `state = IDLE`, `last_grant = D`, so the icache wins the first tie.
  - `mem_read = mem_write = 0`; `mem_address = 0`; `mem_wdata = 0`.
  - `i_pmem_resp = d_pmem_resp = 0`.
- Grant latency:
  - A request visible in `IDLE` at cycle N produces a registered `mem_read` or `mem_write` at cycle N+1.
  - Response pass-through has zero latency, in the same cycle as `mem_resp`.
- Minimum occupancy per transaction is 3 cycles (grant, serve with immediate resp, release). Next sampling is 2 cycles after `mem_resp`.
- Starvation bound: with both caches requesting continuously, grants strictly alternate. A dcache writeback followed by a fill may therefore have an icache read interleaved between them.
- Reset asserted mid-transaction clears all state asynchronously, including outputs and resp. Downstream must also be reset; no transaction resumes.

## Structure
- Package `arb_pkg`:
  - `arb_state_t` enum for the FSM states.
  - `requester_t` enum `{REQ_I, REQ_D}` for `last_grant`.
- Natural sub-module `rr_grant2`: combinational 2-way round-robin pick from `i_req`, `d_req` and `last_grant`.
- The FSM and latches live in `cacheline_arbiter`.

## Test plan
- **Lone icache read.** `i_pmem_read`, address 0x0000_1000; `mem_resp` 4 cycles after `mem_read` with `mem_rdata` = pattern A.
  - `mem_read` rises 1 cycle after the request, with `mem_address = 0x1000`.
  - `i_pmem_resp` pulses 1 cycle with `i_pmem_rdata` = A.
  - `d_pmem_resp` stays 0.
- **Lone dcache writeback.** `d_pmem_write`, address 0x0000_2040, wdata = B.
  - `mem_write` = 1 with `mem_wdata` = B.
  - `d_pmem_resp` pulses on `mem_resp`.
  - `mem_write` = 0 in the following cycle.
- **Tie after reset.** Both caches request in the same cycle.
  - The icache is served first, then the dcache.
  - With both held continuously, grants alternate I, D, I, D.
- **Writeback plus fill with icache pending.** The dcache issues a writeback, then a fill; `i_pmem_read` is held throughout.
  - Order on `mem_*`: D write, I read, D read.
  - Each resp reaches only its owner.
- **Reset mid-transaction.**
  - Drop `rst` to 0 during `SERVE_D`: all outputs go to 0 immediately, with no resp pulse.
  - After `rst` rises with both caches requesting, the icache is granted first.
- **Stray `mem_resp`.** Pulse `mem_resp` in `IDLE` and in `RELEASE`: no resp output and no state change.
